mcpu_fetch: RTL and testbench

Instruction prefetch queue for the MCPU core, sitting between the dual-read-port instruction ROM and the decoder. Each cycle it drives two consecutive ROM addresses, captures up to two bytes into a small byte FIFO, and presents the two oldest bytes with their program counter to the decoder. The decoder consumes 0, 1 or 2 bytes per cycle, which supports variable-length instructions. A jump flushes the queue and restarts fetch at a new address.

---
 rtl/mcpu_fetch_if.sv | 25 ++
 rtl/mcpu_fetch.sv | 66 ++++++
 tb/tb_mcpu_fetch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mcpu_fetch_if.sv
// mcpu_fetch_if: ROM fetch ports plus decoder-side queue view of the prefetch unit
interface mcpu_fetch_if #(
    parameter int IROM_ADDR_BITS = 14,
    parameter int DEPTH          = 4
);
    logic [IROM_ADDR_BITS-1:0]  irom_addr0;
    logic [IROM_ADDR_BITS-1:0]  irom_addr1;
    logic [7:0]                 irom_out0;
    logic [7:0]                 irom_out1;
    logic                       jump_en;
    logic [IROM_ADDR_BITS-1:0]  jump_addr;
    logic [1:0]                 consume;
    logic [$clog2(DEPTH+1)-1:0] avail;
    logic [7:0]                 head0;
    logic [7:0]                 head1;
    logic [IROM_ADDR_BITS-1:0]  head_pc;
    modport master (
        output irom_addr0, irom_addr1, avail, head0, head1, head_pc,
        input  irom_out0, irom_out1, jump_en, jump_addr, consume
    );
    modport slave (
        input  irom_addr0, irom_addr1, avail, head0, head1, head_pc,
        output irom_out0, irom_out1, jump_en, jump_addr, consume
    );
endinterface

// File: rtl/mcpu_fetch.sv
// mcpu_fetch: two-byte-per-cycle instruction prefetch FIFO between the dual-port ROM and the decoder
module mcpu_fetch #(
    parameter int IROM_ADDR_BITS = 14,
    parameter int DEPTH          = 4
) (
    input logic          clk,
    input logic          reset,
    mcpu_fetch_if.master bus
);
    localparam int AW = IROM_ADDR_BITS;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] r_fetch_pc;
    logic [AW-1:0] r_head_pc;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_mem [DEPTH];

    logic [CW-1:0] w_free;
    logic          w_wr2;
    logic [CW-1:0] w_nwr;
    logic [CW-1:0] w_cons;
    logic [CW-1:0] w_c;

    // Write sizing uses the pre-pop count so the ROM path never depends on consume
    always_comb begin
        w_free = CW'(DEPTH) - r_count;
        w_wr2  = w_free >= CW'(2);
        w_nwr  = w_wr2 ? CW'(2) : w_free;
        w_cons = CW'(bus.consume);
        w_c    = (bus.consume != 2'd3 && w_cons <= r_count) ? w_cons : '0;
    end

    assign bus.irom_addr0 = r_fetch_pc;
    assign bus.irom_addr1 = r_fetch_pc + AW'(1);
    assign bus.avail      = r_count;
    assign bus.head_pc    = r_head_pc;
    assign bus.head0      = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.head1      = (r_count >= CW'(2)) ? r_mem[r_rd_ptr + PW'(1)] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= '0;
            r_head_pc  <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else if (bus.jump_en) begin
            r_count    <= '0;
            r_rd_ptr   <= r_wr_ptr;
            r_fetch_pc <= bus.jump_addr;
            r_head_pc  <= bus.jump_addr;
        end else begin
            if (w_nwr != '0) r_mem[r_wr_ptr] <= bus.irom_out0;
            if (w_wr2) r_mem[r_wr_ptr + PW'(1)] <= bus.irom_out1;
            r_wr_ptr   <= r_wr_ptr + PW'(w_nwr);
            r_fetch_pc <= r_fetch_pc + AW'(w_nwr);
            r_rd_ptr   <= r_rd_ptr + PW'(w_c);
            r_head_pc  <= r_head_pc + AW'(w_c);
            r_count    <= r_count + w_nwr - w_c;
        end
    end
endmodule

// File: tb/tb_mcpu_fetch.sv
// tb_mcpu_fetch: directed plus random stimulus checked against a byte-queue reference model
module tb_mcpu_fetch;
    localparam int AW    = 14;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << AW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] rom [0:(1<<AW)-1];

    mcpu_fetch_if #(.IROM_ADDR_BITS(AW), .DEPTH(DEPTH)) bus ();
    mcpu_fetch #(.IROM_ADDR_BITS(AW), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always_comb begin
        bus.irom_out0 = rom[bus.irom_addr0];
        bus.irom_out1 = rom[bus.irom_addr1];
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] q [$];
    int fpc;
    int hpc;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        fpc = 0;
        hpc = 0;
    endtask

    task automatic check_all();
        chk("avail", int'(bus.avail), q.size());
        chk("head0", int'(bus.head0), q.size() > 0 ? int'(q[0]) : 0);
        chk("head1", int'(bus.head1), q.size() > 1 ? int'(q[1]) : 0);
        chk("head_pc", int'(bus.head_pc), hpc);
        chk("addr0", int'(bus.irom_addr0), fpc);
        chk("addr1", int'(bus.irom_addr1), (fpc + 1) & MASK);
    endtask

    // Called at a negedge: check current outputs, apply inputs, advance one edge
    task automatic step(input logic rst, input logic je, input int ja, input int cons);
        int nfree, n, c;
        check_all();
        reset = rst;
        bus.jump_en = je;
        bus.jump_addr = AW'(ja);
        bus.consume = 2'(cons);
        nfree = DEPTH - q.size();
        n = nfree >= 2 ? 2 : nfree;
        c = (cons != 3 && cons <= q.size()) ? cons : 0;
        @(posedge clk);
        if (rst) model_reset();
        else if (je) begin
            q.delete();
            fpc = ja & MASK;
            hpc = ja & MASK;
        end else begin
            for (int i = 0; i < c; i++) void'(q.pop_front());
            for (int i = 0; i < n; i++) q.push_back(rom[(fpc + i) & MASK]);
            fpc = (fpc + n) & MASK;
            hpc = (hpc + c) & MASK;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'(i);
        for (int i = 256; i < (1 << AW); i++) rom[i] = 8'($urandom);
        rom[0] = 8'h00;
        rom[1] = 8'h01;
        reset = 1'b1;
        bus.jump_en = 1'b0;
        bus.jump_addr = '0;
        bus.consume = 2'd0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("fill_avail2", int'(bus.avail), 2);
        chk("fill_head_pc", int'(bus.head_pc), 0);
        step(0, 0, 0, 0);
        chk("fill_avail4", int'(bus.avail), 4);
        step(0, 0, 0, 0);
        chk("fill_hold4", int'(bus.avail), 4);
        chk("fill_head0", int'(bus.head0), 0);
        chk("fill_head1", int'(bus.head1), 1);
        chk("fill_addr0", int'(bus.irom_addr0), 4);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 2);
        chk("stream_head_pc", int'(bus.head_pc), 12);
        chk("stream_head0", int'(bus.head0), 12);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 2);
        step(0, 0, 0, 1);
        chk("mixed_head_pc", int'(bus.head_pc), 16);
        step(0, 1, 'h100, 2);
        chk("jump_avail0", int'(bus.avail), 0);
        chk("jump_pc", int'(bus.head_pc), 'h100);
        step(0, 0, 0, 2);
        chk("jump_avail2", int'(bus.avail), 2);
        chk("jump_head0", int'(bus.head0), int'(rom[16'h100]));
        step(0, 1, 'h3FFF, 0);
        chk("wrap_addr1", int'(bus.irom_addr1), 0);
        step(0, 0, 0, 0);
        chk("wrap_head0", int'(bus.head0), int'(rom[16'h3FFF]));
        chk("wrap_head1", int'(bus.head1), int'(rom[0]));
        step(0, 0, 0, 1);
        chk("wrap_head_pc", int'(bus.head_pc), 0);
        step(0, 1, 'h40, 0);
        step(0, 0, 0, 2);
        chk("over_ignored", int'(bus.head_pc), 'h40);
        step(0, 0, 0, 3);
        step(0, 0, 0, 3);
        chk("illegal3_pc", int'(bus.head_pc), 'h40);
        step(1, 0, 0, 2);
        chk("rst_avail", int'(bus.avail), 0);
        chk("rst_addr0", int'(bus.irom_addr0), 0);
        chk("rst_head0", int'(bus.head0), 0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, MASK)), int'($urandom_range(0, 3)));
        end
        check_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
